// File: rtl/bin_bcd_pkg.sv
// Shared constants, FSM state type and seven-segment patterns for the
// 20-bit binary to 6-digit BCD converter.
package bin_bcd_pkg;

  localparam int DIGITS     = 6;
  localparam int BIN_W      = 20;
  localparam int ITER       = 20;
  localparam int BCD_DIGITS = 7;
  localparam int BCD_W      = BCD_DIGITS * 4;
  localparam int CNT_W      = 5;

  // Active-low patterns, bit6 = g ... bit0 = a; codes 10-15 are blank.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_PAT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, SEG_BLANK,  SEG_BLANK,
    SEG_BLANK,  SEG_BLANK,  SEG_BLANK,  SEG_BLANK
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_t;

endpackage

// File: rtl/bin20_to_6_bcd_if.sv
// Request/status handshake between a conversion requester and the converter.
interface bin20_to_6_bcd_if
  import bin_bcd_pkg::*;
  ();
  logic             start;
  logic [BIN_W-1:0] binary;
  logic             busy;
  logic             done;

  modport master (output start, binary, input busy, done);
  modport slave  (input start, binary, output busy, done);
endinterface

// File: rtl/bcd_to_seg.sv
// One BCD digit to an active-low seven-segment pattern, with forced blanking.
module bcd_to_seg
  import bin_bcd_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  assign seg = blank ? SEG_BLANK : SEG_PAT[bcd];

endmodule

// File: rtl/bin20_to_6_bcd.sv
// Sequential double-dabble converter: 20-bit unsigned to six saturating BCD
// digits plus overflow, with decoded seven-segment outputs.
module bin20_to_6_bcd
  import bin_bcd_pkg::*;
#(
  parameter int BLANK_LZ = 0
) (
  input  logic             CLK,
  input  logic             reset,
  bin20_to_6_bcd_if.slave  bus,
  output logic [3:0]       D0,
  output logic [3:0]       D1,
  output logic [3:0]       D2,
  output logic [3:0]       D3,
  output logic [3:0]       D4,
  output logic [3:0]       D5,
  output logic             ovf,
  output logic [6:0]       HEX0,
  output logic [6:0]       HEX1,
  output logic [6:0]       HEX2,
  output logic [6:0]       HEX3,
  output logic [6:0]       HEX4,
  output logic [6:0]       HEX5
);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg;
  logic [BIN_W-1:0]   bin_reg;
  logic [BCD_W-1:0]   bcd_reg;
  logic [BCD_W-1:0]   bcd_adj;
  logic [3:0]         d_reg [DIGITS];
  logic               ovf_reg;
  logic               done_reg;
  logic               accept, shift_en, load_en;

  always_ff @(posedge CLK) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    shift_en   = 1'b0;
    load_en    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (cnt_reg == CNT_W'(ITER - 1)) state_next = LOAD;
      end
      LOAD: begin
        load_en    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Add-3 correction on every digit before the shift.
  for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_adj
    assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                bcd_reg[gi*4 +: 4] + 4'd3 : bcd_reg[gi*4 +: 4];
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      cnt_reg  <= '0;
      bin_reg  <= '0;
      bcd_reg  <= '0;
      ovf_reg  <= 1'b0;
      done_reg <= 1'b0;
      for (int i = 0; i < DIGITS; i++) d_reg[i] <= 4'd0;
    end else begin
      done_reg <= load_en;
      if (accept) begin
        bin_reg <= bus.binary;
        bcd_reg <= '0;
        cnt_reg <= '0;
      end
      if (shift_en) begin
        bcd_reg <= {bcd_adj[BCD_W-2:0], bin_reg[BIN_W-1]};
        bin_reg <= {bin_reg[BIN_W-2:0], 1'b0};
        cnt_reg <= cnt_reg + 1'b1;
      end
      // The top digit is nonzero only for values above 999999.
      if (load_en) begin
        ovf_reg <= |bcd_reg[BCD_W-1 -: 4];
        for (int i = 0; i < DIGITS; i++)
          d_reg[i] <= (|bcd_reg[BCD_W-1 -: 4]) ? 4'd9 : bcd_reg[i*4 +: 4];
      end
    end
  end

  assign bus.busy = (state_reg != IDLE);
  assign bus.done = done_reg;
  assign ovf      = ovf_reg;

  assign D0 = d_reg[0];
  assign D1 = d_reg[1];
  assign D2 = d_reg[2];
  assign D3 = d_reg[3];
  assign D4 = d_reg[4];
  assign D5 = d_reg[5];

  // zero_up[n] is set when digit n and every higher digit are zero.
  logic [DIGITS:0] zero_up;
  logic [6:0]      hex [DIGITS];
  assign zero_up[DIGITS] = 1'b1;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_seg
    logic blank;
    assign zero_up[gi] = (d_reg[gi] == 4'd0) && zero_up[gi+1];
    assign blank       = (BLANK_LZ != 0) && (gi != 0) && zero_up[gi];
    bcd_to_seg u_seg (
      .bcd   (d_reg[gi]),
      .blank (blank),
      .seg   (hex[gi])
    );
  end

  assign HEX0 = hex[0];
  assign HEX1 = hex[1];
  assign HEX2 = hex[2];
  assign HEX3 = hex[3];
  assign HEX4 = hex[4];
  assign HEX5 = hex[5];

endmodule

// File: tb/tb_bin20_to_6_bcd.sv
// Directed bench for bin20_to_6_bcd: two instances (no blanking / blanking)
// share clock, reset and stimulus; results are checked from a scoreboard.
module tb_bin20_to_6_bcd;

  logic CLK = 1'b0;
  logic reset;
  always #5 CLK = ~CLK;

  bin20_to_6_bcd_if bus0 ();
  bin20_to_6_bcd_if bus1 ();

  logic [3:0] d0 [6];
  logic [3:0] d1 [6];
  logic       ovf0, ovf1;
  logic [6:0] h0 [6];
  logic [6:0] h1 [6];

  bin20_to_6_bcd #(.BLANK_LZ(0)) dut0 (
    .CLK(CLK), .reset(reset), .bus(bus0),
    .D0(d0[0]), .D1(d0[1]), .D2(d0[2]), .D3(d0[3]), .D4(d0[4]), .D5(d0[5]),
    .ovf(ovf0),
    .HEX0(h0[0]), .HEX1(h0[1]), .HEX2(h0[2]), .HEX3(h0[3]), .HEX4(h0[4]), .HEX5(h0[5])
  );

  bin20_to_6_bcd #(.BLANK_LZ(1)) dut1 (
    .CLK(CLK), .reset(reset), .bus(bus1),
    .D0(d1[0]), .D1(d1[1]), .D2(d1[2]), .D3(d1[3]), .D4(d1[4]), .D5(d1[5]),
    .ovf(ovf1),
    .HEX0(h1[0]), .HEX1(h1[1]), .HEX2(h1[2]), .HEX3(h1[3]), .HEX4(h1[4]), .HEX5(h1[5])
  );

  typedef struct {
    int unsigned val;
    logic [3:0]  d [6];
    logic        ovf;
  } exp_t;

  exp_t sb [$];
  int   vectors    = 0;
  int   miscompares = 0;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input int unsigned v);
    exp_t e;
    int unsigned t;
    e.val = v;
    e.ovf = (v > 999999);
    t = v;
    for (int i = 0; i < 6; i++) begin
      e.d[i] = e.ovf ? 4'd9 : 4'(t % 10);
      t = t / 10;
    end
    sb.push_back(e);
  endtask

  task automatic drive(input logic s, input int unsigned v);
    bus0.start  = s;
    bus0.binary = 20'(v);
    bus1.start  = s;
    bus1.binary = 20'(v);
  endtask

  // One conversion; optional stray start with another value at cycle 5.
  task automatic run(input int unsigned v, input int unsigned stray);
    int   lat;
    int   busy_cnt;
    exp_t e;
    push_exp(v);
    drive(1'b1, v);
    @(negedge CLK);
    drive(1'b0, v);
    lat = 0;
    busy_cnt = 0;
    while (!bus0.done && lat < 40) begin
      if (bus0.busy) busy_cnt++;
      if (stray != 0 && lat == 5) drive(1'b1, stray);
      if (stray != 0 && lat == 6) drive(1'b0, stray);
      @(negedge CLK);
      lat++;
    end
    chk($sformatf("done_seen_%0d", v), 32'(bus0.done), 32'd1);
    chk($sformatf("latency_%0d", v), 32'(lat), 32'd21);
    chk($sformatf("busy_cycles_%0d", v), 32'(busy_cnt), 32'd21);
    chk($sformatf("busy_low_at_done_%0d", v), 32'(bus0.busy), 32'd0);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk($sformatf("ovf_%0d", e.val), 32'(ovf0), 32'(e.ovf));
      chk($sformatf("ovf_blank_inst_%0d", e.val), 32'(ovf1), 32'(e.ovf));
      for (int i = 0; i < 6; i++) begin
        chk($sformatf("D%0d_%0d", i, e.val), 32'(d0[i]), 32'(e.d[i]));
        chk($sformatf("D%0d_blank_inst_%0d", i, e.val), 32'(d1[i]), 32'(e.d[i]));
        chk($sformatf("HEX%0d_%0d", i, e.val), 32'(h0[i]), 32'(seg_of(e.d[i])));
      end
    end
    @(negedge CLK);
    chk($sformatf("done_one_cycle_%0d", v), 32'(bus0.done), 32'd0);
  endtask

  initial begin
    int seen_done;
    reset = 1'b1;
    drive(1'b0, 0);
    repeat (3) @(negedge CLK);
    reset = 1'b0;
    @(negedge CLK);

    chk("rst_busy", 32'(bus0.busy), 32'd0);
    chk("rst_done", 32'(bus0.done), 32'd0);
    chk("rst_ovf", 32'(ovf0), 32'd0);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("rst_D%0d", i), 32'(d0[i]), 32'd0);
      chk($sformatf("rst_HEX%0d", i), 32'(h0[i]), 32'h40);
      chk($sformatf("rst_blank_HEX%0d", i), 32'(h1[i]), (i == 0) ? 32'h40 : 32'h7F);
    end

    run(0, 0);
    run(987654, 0);
    chk("hex0_987654", 32'(h0[0]), 32'h19);
    run(999999, 0);
    run(1000000, 0);
    run(1048575, 0);
    run(54321, 777777);

    run(42, 0);
    chk("blank_HEX0_42", 32'(h1[0]), 32'h24);
    chk("blank_HEX1_42", 32'(h1[1]), 32'h19);
    for (int i = 2; i < 6; i++)
      chk($sformatf("blank_HEX%0d_42", i), 32'(h1[i]), 32'h7F);
    chk("noblank_HEX2_42", 32'(h0[2]), 32'h40);

    // Abort a conversion with reset on edge k+10.
    drive(1'b1, 123456);
    @(negedge CLK);
    drive(1'b0, 123456);
    repeat (9) @(negedge CLK);
    reset = 1'b1;
    @(negedge CLK);
    reset = 1'b0;
    chk("abort_busy", 32'(bus0.busy), 32'd0);
    chk("abort_done", 32'(bus0.done), 32'd0);
    chk("abort_ovf", 32'(ovf0), 32'd0);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("abort_D%0d", i), 32'(d0[i]), 32'd0);
      chk($sformatf("abort_blank_HEX%0d", i), 32'(h1[i]), (i == 0) ? 32'h40 : 32'h7F);
    end
    seen_done = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      if (bus0.done || bus1.done) seen_done = 1;
    end
    chk("abort_no_done", 32'(seen_done), 32'd0);
    chk("abort_busy_after", 32'(bus0.busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bin20_to_6_bcd.md
BIN20_TO_6_BCD -- requirements
Module: bin20_to_6_bcd

Interface
REQ-001 The block SHALL have parameter BLANK_LZ, default 0; when 1, leading-zero digits on HEX outputs are blanked (HEX0 never blanked).
REQ-002 The block SHALL have port CLK, input, 1 bit: sole clock; all state updates on rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: conversion request, sampled each edge.
REQ-005 The block SHALL have port binary, input, 20 bits: unsigned value to convert, captured when start is accepted.
REQ-006 The block SHALL have ports D0..D5, output, 4 bits each: registered BCD digits (D0 = units, D5 = hundred-thousands).
REQ-007 The block SHALL have port ovf, output, 1 bit: registered flag, last value exceeded 999999.
REQ-008 The block SHALL have port busy, output, 1 bit: conversion in progress.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-010 The block SHALL have ports HEX0..HEX5, output, 7 bits each: active-low seven-segment patterns for D0..D5; bit0 = segment a … bit6 = segment g.

Function
REQ-011 The block SHALL accept start only when busy=0; start while busy=1 is ignored with no effect on the running conversion.
REQ-012 On an accepted start edge (edge k), the block SHALL capture binary, clear its internal BCD shift register, and set busy=1.
REQ-013 On edges k+1..k+20, the block SHALL perform one double-dabble iteration per edge, MSB first: add 3 to every internal digit >=5, then shift left one bit.
REQ-014 The internal BCD register SHALL be 7 digits (28 bits) wide so that 1048575 converts without loss.
REQ-015 On edge k+21, the block SHALL load D5..D0 and ovf, pulse done=1 for exactly one cycle, and clear busy to 0.
REQ-016 If the converted value is <=999999, the block SHALL set D5..D0 to its decimal digits and ovf=0.
REQ-017 If the converted value is >999999, the block SHALL set ovf=1 and saturate D5..D0 to 9,9,9,9,9,9.
REQ-018 D0..D5 and ovf SHALL hold their values between completions; the HEX outputs SHALL be combinational decodes of the D registers.
REQ-019 A start asserted on the edge where done=1 SHALL be accepted, making back-to-back conversions every 22 cycles.
REQ-020 The decoder SHALL map 0-9 to the following active-low patterns, listed g..a: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-021 The decoder SHALL map codes 10-15 to 1111111 (blank).
REQ-022 When BLANK_LZ=1, the block SHALL drive HEXn (n>=1) to 1111111 if Dn and all higher digits are 0.

Reset
REQ-023 When reset=1 at an edge, the block SHALL set D0..D5=0, ovf=0, busy=0, done=0, and clear the internal registers, aborting any conversion in progress.
REQ-024 Reset SHALL take priority over start on the same edge.
REQ-025 After reset, HEX0..HEX5 SHALL equal 1000000 when BLANK_LZ=0; when BLANK_LZ=1, HEX0=1000000 and HEX1..HEX5=1111111.

Structure
REQ-026 The design SHALL place constants DIGITS=6, BIN_W=20, ITER=20 and the seven-segment pattern constants in a shared package bin_bcd_pkg.
REQ-027 The design SHALL implement the BCD-to-seven-segment decoder as one combinational sub-module, bcd_to_seg, instantiated six times.
REQ-028 The converter control SHALL be a three-state FSM: IDLE, SHIFT (20-count iteration counter), LOAD.

Verification
REQ-029 The bench SHALL cover: reset, then binary=0 with start -> done at edge +21, all D=0, ovf=0, all HEX=1000000.
REQ-030 The bench SHALL cover: binary=987654 with start -> D5..D0=9,8,7,6,5,4, ovf=0, HEX0=0011001.
REQ-031 The bench SHALL cover: binary=999999 -> ovf=0, all digits 9; then binary=1000000 -> ovf=1, all digits 9.
REQ-032 The bench SHALL cover: binary=1048575 -> ovf=1, digits saturated to 9; busy high for exactly 21 cycles.
REQ-033 The bench SHALL cover: start pulsed again mid-conversion with a different binary -> ignored; first result delivered unchanged.
REQ-034 The bench SHALL cover: reset asserted at edge +10 of a conversion -> busy=0 and done never pulses; outputs zero; BLANK_LZ=1 with value 42 -> HEX2..HEX5=1111111.
